sdram_burst_arbiter: RTL and testbench
======================================

# sdram_burst_arbiter

Shares the single SDRAM controller command port between the write FIFO (camera/test data into SDRAM) and the read FIFO (SDRAM data out to the LCD path). It schedules fixed-length bursts from FIFO fill levels and arbitrates round-robin when both sides are ready. It generates wrapping frame-buffer addresses for each direction and sits between the FIFO pair and the SDRAM controller core.

## Interface
- ADDR_W, 24, SDRAM word-address width
- LVL_W, 11, FIFO level width
- FIFO_DEPTH, 1024, read FIFO depth in words
- BURST_LEN, 256, words per burst (power of two, ≤ FIFO_DEPTH/2)
- WR_BASE / WR_END, 0 / 480000, write region [base, end)
- RD_BASE / RD_END, 0 / 480000, read region [base, end)

Ports:
- clk_50m  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- sdram_init_done  in  1  controller init complete (asynchronous, synchronised here)
- wr_fifo_level  in  LVL_W  words waiting in write FIFO
- rd_fifo_level  in  LVL_W  words held in read FIFO
- wr_load / rd_load  in  1  one-cycle pulse: restart that address at its base (frame start)
- cmd_valid  out  1  burst request to core
- cmd_ready  in  1  core accepts request
- cmd_write  out  1  1 = write burst, 0 = read burst
- cmd_addr  out  ADDR_W  burst start address
- cmd_len  out  LVL_W  always BURST_LEN
- burst_done  in  1  one-cycle pulse, current burst finished
- busy  out  1  high from grant until burst_done

## Operation
- sdram_init_done passes a 2-flop synchroniser; no grant while synchronised value is 0.
- wr_req = wr_fifo_level ≥ BURST_LEN; rd_req = (FIFO_DEPTH − rd_fifo_level) ≥ BURST_LEN.
- FSM: IDLE → ISSUE → WAIT_DONE → IDLE.
  - IDLE: if a request exists, pick a winner, register cmd_valid=1, cmd_write, cmd_addr, busy=1; go ISSUE.
  - ISSUE: hold cmd_valid and all fields stable until cmd_ready=1. On that edge drop cmd_valid and go WAIT_DONE.
  - WAIT_DONE: on burst_done, advance the granted address by BURST_LEN, drop busy, go IDLE.
- Round-robin: when both requests are asserted, grant the direction not served last. last_grant resets to read, so the first contested grant goes to write.
- Address wrap: if addr + BURST_LEN ≥ END, the next address is BASE. Arithmetic is ADDR_W+1 bits to avoid overflow.
- wr_load/rd_load:
  - If that direction is not in flight, its address is set to BASE next cycle.
  - If that direction is in flight, the load is latched as pending and applied at burst_done instead of the advance.
- burst_done outside WAIT_DONE is ignored. cmd_ready outside ISSUE is ignored.
- Deassertion of sdram_init_done mid-burst does not abort the burst; it only blocks new grants.

## Timing
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=0, busy=0, cmd_len=BURST_LEN, wr/rd addresses=BASE, state IDLE, last_grant=read, pending loads=0.
- Request to cmd_valid: 1 cycle. Level inputs are sampled in IDLE.
- cmd_ready high in the first ISSUE cycle gives a one-cycle cmd_valid pulse.
- burst_done to next cmd_valid: minimum 2 cycles, since IDLE always lasts at least one cycle so FIFO levels settle.
- Reset mid-burst: all state returns to reset values immediately.

## Configuration
- SDRAM_ARB_WR_PRIORITY_EN defined: fixed priority; write always wins when wr_req=1, and last_grant is unused. This protects the camera path from overflow.
- Undefined: round-robin as above.

## Structure
- Package sdram_arb_pkg holds the state enum (IDLE, ISSUE, WAIT_DONE), the grant encoding (GNT_RD=0, GNT_WR=1) and a burst-length constant default.
- Sub-module sdram_addr_gen, instanced twice (write, read): holds BASE/END/STEP, the wrapping address, the pending load and the advance input.

## Test plan
- Reset, init_done=0, wr_fifo_level=300 → no cmd_valid. Raise init_done → cmd_valid 3 cycles later (2 sync + 1) with write=1, addr=0.
- Both requests pending continuously, cmd_ready tied 1, burst_done 10 cycles after each accept → grants alternate W,R,W,R; write addresses 0,256,512.
- Write region END=768, four write bursts → addresses 0,256,512,0.
- cmd_ready held 0 for 5 cycles → cmd_valid/addr/write stable for 5 cycles; accepted on cycle 6.
- rd_load pulsed during an in-flight read at addr 512 → next read addr=RD_BASE, not 768.
- With SDRAM_ARB_WR_PRIORITY_EN, both requests always pending → every grant is write.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM burst arbiter: FSM states, grant encoding and
// the default burst length.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    localparam int unsigned BURST_LEN_DEFAULT = 256;

endpackage

// File: rtl/sdram_addr_gen.sv
// Wrapping frame-buffer address generator for one transfer direction.
// A load while the direction is in flight is held pending and replaces the
// next advance, so a burst never sees its own start address move under it.
module sdram_addr_gen #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned END_ADDR  = 480000,
    parameter int unsigned STEP      = 256
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              load,
    input  logic              in_flight,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   END_X  = (ADDR_W + 1)'(END_ADDR);
    localparam logic [ADDR_W:0]   STEP_X = (ADDR_W + 1)'(STEP);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W:0]   sum;

    // Next address: advance with wrap, or restart at base on a load.
    always_comb begin
        sum    = {1'b0, addr_q} + STEP_X;
        addr_d = addr_q;
        pend_d = pend_q;
        if (advance) begin
            pend_d = 1'b0;
            if (pend_q || load) begin
                addr_d = BASE_A;
            end else if (sum >= END_X) begin
                addr_d = BASE_A;
            end else begin
                addr_d = sum[ADDR_W-1:0];
            end
        end else if (load) begin
            if (in_flight) begin
                pend_d = 1'b1;
            end else begin
                addr_d = BASE_A;
            end
        end
    end

    // Address and pending-load registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE_A;
            pend_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pend_q <= pend_d;
        end
    end

    // Forward a same-cycle idle load so a grant issued now uses the base.
    assign addr = (load && !in_flight) ? BASE_A : addr_q;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates the SDRAM controller command port between the write FIFO and the
// read FIFO. Bursts are requested from FIFO fill levels; contested grants are
// round-robin, or fixed write priority when SDRAM_ARB_WR_PRIORITY_EN is defined.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned LVL_W      = 11,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT,
    parameter int unsigned WR_BASE    = 0,
    parameter int unsigned WR_END     = 480000,
    parameter int unsigned RD_BASE    = 0,
    parameter int unsigned RD_END     = 480000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic              wr_load,
    input  logic              rd_load,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LVL_W-1:0]  cmd_len,
    input  logic              burst_done,
    output logic              busy
);

    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
    // Read side requests while free space >= BURST_LEN, i.e. level <= depth - burst.
    localparam logic [LVL_W-1:0] RD_MAX_LVL = LVL_W'(FIFO_DEPTH - BURST_LEN);

    logic              init_meta, init_sync;
    logic              wr_req, rd_req;
    logic              wr_adv, rd_adv;
    logic              wr_in_flight, rd_in_flight;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    arb_state_e        state_q, state_d;
    grant_e            gnt_q, gnt_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            pick;
    logic              cmd_valid_q, cmd_valid_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

    assign wr_req       = (wr_fifo_level >= BURST_LVL);
    assign rd_req       = (rd_fifo_level <= RD_MAX_LVL);
    assign wr_in_flight = busy_q && (gnt_q == GNT_WR);
    assign rd_in_flight = busy_q && (gnt_q == GNT_RD);

    // Two-flop synchroniser for the controller's init flag.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            init_meta <= 1'b0;
            init_sync <= 1'b0;
        end else begin
            init_meta <= sdram_init_done;
            init_sync <= init_meta;
        end
    end

    // Grant choice, next state and registered command fields.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cmd_valid_d  = cmd_valid_q;
        busy_d       = busy_q;
        cmd_addr_d   = cmd_addr_q;
        wr_adv       = 1'b0;
        rd_adv       = 1'b0;
`ifdef SDRAM_ARB_WR_PRIORITY_EN
        pick = wr_req ? GNT_WR : GNT_RD;
`else
        if (wr_req && rd_req) begin
            pick = (last_grant_q == GNT_RD) ? GNT_WR : GNT_RD;
        end else begin
            pick = wr_req ? GNT_WR : GNT_RD;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (init_sync && (wr_req || rd_req)) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    cmd_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    cmd_addr_d   = (pick == GNT_WR) ? wr_addr : rd_addr;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (burst_done) begin
                    busy_d  = 1'b0;
                    wr_adv  = (gnt_q == GNT_WR);
                    rd_adv  = (gnt_q == GNT_RD);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and command register bank.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_RD;
            last_grant_q <= GNT_RD;
            cmd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmd_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cmd_valid_q  <= cmd_valid_d;
            busy_q       <= busy_d;
            cmd_addr_q   <= cmd_addr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_write = (gnt_q == GNT_WR);
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = BURST_LVL;
    assign busy      = busy_q;

    sdram_addr_gen #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(WR_BASE),
        .END_ADDR (WR_END),
        .STEP     (BURST_LEN)
    ) u_wr_addr (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .load     (wr_load),
        .in_flight(wr_in_flight),
        .advance  (wr_adv),
        .addr     (wr_addr)
    );

    sdram_addr_gen #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(RD_BASE),
        .END_ADDR (RD_END),
        .STEP     (BURST_LEN)
    ) u_rd_addr (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .load     (rd_load),
        .in_flight(rd_in_flight),
        .advance  (rd_adv),
        .addr     (rd_addr)
    );

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Scoreboard bench for sdram_burst_arbiter. Write region is shrunk to 768
// words so wrap-around is reached in a few bursts.
module tb_sdram_burst_arbiter;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned LVL_W    = 11;
    localparam int unsigned DONE_DLY = 10;

    logic              clk_50m = 1'b0;
    logic              rst_n;
    logic              sdram_init_done;
    logic [LVL_W-1:0]  wr_fifo_level;
    logic [LVL_W-1:0]  rd_fifo_level;
    logic              wr_load;
    logic              rd_load;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LVL_W-1:0]  cmd_len;
    logic              burst_done;
    logic              busy;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        int                cyc;   // expected negedge index of first valid, 0 = any
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    logic seen     = 1'b0;
    logic drop_chk = 1'b0;
    logic busy_chk = 1'b0;
    logic inflight = 1'b0;

    always #10 clk_50m = ~clk_50m;

    sdram_burst_arbiter #(
        .WR_END(768)
    ) dut (
        .clk_50m        (clk_50m),
        .rst_n          (rst_n),
        .sdram_init_done(sdram_init_done),
        .wr_fifo_level  (wr_fifo_level),
        .rd_fifo_level  (rd_fifo_level),
        .wr_load        (wr_load),
        .rd_load        (rd_load),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .burst_done     (burst_done),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic wr, input int unsigned addr, input int cyc);
        exp_t e;
        e.wr   = wr;
        e.addr = ADDR_W'(addr);
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_size(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_50m);
            #1;
            if (sb.size() == n) return;
        end
        $display("FAIL scoreboard_timeout: got %0d pending expected %0d", sb.size(), n);
        $fatal(1, "scoreboard wait expired");
    endtask

    // Monitor: compares every presented command against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk_50m);
            ncyc++;
            if (!rst_n) begin
                chk("rst_valid", 32'(cmd_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_write", 32'(cmd_write), 32'd0);
                chk("rst_addr", 32'(cmd_addr), 32'd0);
                chk("rst_len", 32'(cmd_len), 32'd256);
                seen     = 1'b0;
                drop_chk = 1'b0;
                busy_chk = 1'b0;
                inflight = 1'b0;
            end else begin
                if (drop_chk) begin
                    chk("valid_drop", 32'(cmd_valid), 32'd0);
                    drop_chk = 1'b0;
                end
                if (busy_chk) begin
                    chk("busy_drop", 32'(busy), 32'd0);
                    busy_chk = 1'b0;
                end
                if (burst_done && inflight) begin
                    busy_chk = 1'b1;
                    inflight = 1'b0;
                end
                if (cmd_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_cmd", 32'(cmd_valid), 32'd0);
                    end else begin
                        chk("cmd_write", 32'(cmd_write), 32'(sb[0].wr));
                        chk("cmd_addr", 32'(cmd_addr), 32'(sb[0].addr));
                        chk("busy_with_valid", 32'(busy), 32'd1);
                        chk("cmd_len", 32'(cmd_len), 32'd256);
                        if (sb[0].cyc != 0 && !seen) begin
                            chk("valid_latency", 32'(ncyc), 32'(sb[0].cyc));
                        end
                        seen = 1'b1;
                        if (cmd_ready) begin
                            void'(sb.pop_front());
                            seen     = 1'b0;
                            drop_chk = 1'b1;
                            inflight = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Controller model: pulse burst_done a fixed delay after each accept.
    initial begin
        burst_done = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (rst_n && cmd_valid && cmd_ready) begin
                repeat (DONE_DLY) @(posedge clk_50m);
                #1 burst_done = 1'b1;
                @(posedge clk_50m);
                #1 burst_done = 1'b0;
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_level   = 11'd300;
        rd_fifo_level   = 11'd1024;
        wr_load         = 1'b0;
        rd_load         = 1'b0;
        cmd_ready       = 1'b1;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;

        // Init gating, then write-only bursts wrapping at 768.
        repeat (10) @(posedge clk_50m);
        #1;
        push(1'b1, 0, ncyc + 4);
        push(1'b1, 256, 0);
        push(1'b1, 512, 0);
        push(1'b1, 0, 0);
        sdram_init_done = 1'b1;
        wait_size(0, 300);
        wr_fifo_level = 11'd0;
        repeat (20) @(posedge clk_50m);

        // Fresh reset, then both sides contending.
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;
`ifdef SDRAM_ARB_WR_PRIORITY_EN
        push(1'b1, 0, 0);
        push(1'b1, 256, 0);
        push(1'b1, 512, 0);
        push(1'b1, 0, 0);
        wr_fifo_level = 11'd300;
        rd_fifo_level = 11'd0;
`else
        push(1'b1, 0, 0);
        push(1'b0, 0, 0);
        push(1'b1, 256, 0);
        push(1'b0, 256, 0);
        push(1'b1, 512, 0);
        push(1'b0, 512, 0);
        push(1'b1, 0, 0);
        push(1'b0, 0, 0);   // rd_load during the 512 read restarts at base
        wr_fifo_level = 11'd300;
        rd_fifo_level = 11'd0;
        wait_size(2, 400);
        repeat (2) @(posedge clk_50m);
        #1 rd_load = 1'b1;
        @(posedge clk_50m);
        #1 rd_load = 1'b0;
`endif
        wait_size(0, 400);
        wr_fifo_level = 11'd0;
        rd_fifo_level = 11'd1024;
        repeat (20) @(posedge clk_50m);

        // Back-pressure: fields must hold while cmd_ready is low.
        #1;
        cmd_ready = 1'b0;
        push(1'b1, 256, 0);
        wr_fifo_level = 11'd300;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_50m);
            #1;
            if (cmd_valid) break;
        end
        if (!cmd_valid) begin
            $display("FAIL backpressure_timeout: got cmd_valid %0d expected 1", cmd_valid);
            $fatal(1, "no command under back-pressure");
        end
        repeat (5) @(posedge clk_50m);
        #1 cmd_ready = 1'b1;
        wait_size(0, 20);
        wr_fifo_level = 11'd0;
        repeat (20) @(posedge clk_50m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
